// File: rtl/shared_pipe_arb_pkg.sv
// Shared definitions for the shared-pipeline arbiter: width helpers and the
// round-robin pick function that other arbiters in the design reuse.
package shared_pipe_arb_pkg;

    localparam int MAX_REQ = 32;

    function automatic int tag_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    function automatic int cnt_w(input int latency);
        return $clog2(latency + 2);
    endfunction

    // Rotate so that position 0 is the requester after `last`, then take the
    // lowest set position. Returns the winning index, or -1 when nobody asks.
    function automatic int rr_pick(input logic [MAX_REQ-1:0] req,
                                   input int                 n,
                                   input int                 last);
        logic [MAX_REQ-1:0] rot;
        int                 pick;
        rot = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                rot[k] = |(req & (MAX_REQ'(1) << ((last + 1 + k) % n)));
            end
        end
        pick = -1;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                pick = (last + 1 + k) % n;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/shared_pipe_arb_if.sv
// Requester-side bundle of the shared-pipeline arbiter.
// req: a transfer happens in a cycle where req_vld[i] & req_rdy[i]; req_rdy is
// one-hot-or-zero and may depend combinationally on req_vld. rsp: rsp_vld is a
// one-hot-or-zero strobe with no backpressure; rsp_dat is meaningful only then.
interface shared_pipe_arb_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16
);
    logic [NUM_REQ-1:0]            req_vld;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_dat;
    logic [NUM_REQ-1:0]            req_rdy;
    logic [NUM_REQ-1:0]            rsp_vld;
    logic [DATA_WIDTH-1:0]         rsp_dat;

    modport master (
        output req_vld,
        output req_dat,
        input  req_rdy,
        input  rsp_vld,
        input  rsp_dat
    );

    modport slave (
        input  req_vld,
        input  req_dat,
        output req_rdy,
        output rsp_vld,
        output rsp_dat
    );
endinterface

// File: rtl/shared_pipe_arb_tag_delay.sv
// Fixed-depth delay line for {valid, tag}; every stage clears on reset so no
// stale valid can escape after a reset. STAGES=0 degenerates to a wire.
module tag_delay #(
    parameter int STAGES = 1,
    parameter int WIDTH  = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (STAGES == 0) begin : g_wire
        assign q_o = d_i;
    end else begin : g_shift
        logic [WIDTH-1:0] stage_q [STAGES];
        logic [WIDTH-1:0] stage_d [STAGES];

        always_comb begin
            stage_d[0] = d_i;
            for (int s = 1; s < STAGES; s++) begin
                stage_d[s] = stage_q[s-1];
            end
        end

        always_ff @(posedge clk_i) begin
            for (int s = 0; s < STAGES; s++) begin
                if (!rst_ni) begin
                    stage_q[s] <= '0;
                end else begin
                    stage_q[s] <= stage_d[s];
                end
            end
        end

        assign q_o = stage_q[STAGES-1];
    end

endmodule

// File: rtl/shared_pipe_arb.sv
// Round-robin arbiter that shares one fixed-latency, non-stallable pipeline
// among NUM_REQ requesters and steers each result back to its originator.
module shared_pipe_arb
    import shared_pipe_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int LATENCY    = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         hold_i,
    shared_pipe_arb_if.slave             req_if,
    output logic                         pipe_din_vld_o,
    output logic [DATA_WIDTH-1:0]        pipe_din_o,
    input  logic [DATA_WIDTH-1:0]        pipe_dout_i,
    output logic [cnt_w(LATENCY)-1:0]    inflight_o,
    output logic                         idle_o
);

    localparam int TAG_W = tag_w(NUM_REQ);
    localparam int CNT_W = cnt_w(LATENCY);

    logic [TAG_W-1:0]      ptr_q, ptr_d;
    logic [TAG_W-1:0]      gnt_idx;
    logic [NUM_REQ-1:0]    gnt_oh;
    logic                  grant_en;
    logic                  xfer;
    int                    pick;

    logic                  din_vld_q, din_vld_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic [TAG_W-1:0]      tag_q, tag_d;

    logic                  dly_vld;
    logic [TAG_W-1:0]      dly_tag;
    logic [NUM_REQ-1:0]    rsp_oh;
    logic                  rsp_any;

    logic [CNT_W-1:0]      cnt_q, cnt_d;

    // Grants are gated by reset as well as HOLD so nothing transfers while
    // the launch and tag registers are being cleared.
    always_comb begin
        pick     = rr_pick(MAX_REQ'(req_if.req_vld), NUM_REQ, int'(ptr_q));
        grant_en = rst_ni && !hold_i && (pick >= 0);
        gnt_oh   = '0;
        gnt_idx  = ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_en && (pick == i)) begin
                gnt_oh[i] = 1'b1;
                gnt_idx   = TAG_W'(i);
            end
        end
        xfer  = |(req_if.req_vld & gnt_oh);
        ptr_d = xfer ? gnt_idx : ptr_q;
    end

    assign req_if.req_rdy = gnt_oh;

    always_comb begin
        din_vld_d = xfer;
        din_d     = din_q;
        tag_d     = tag_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_oh[i]) begin
                din_d = req_if.req_dat[i*DATA_WIDTH +: DATA_WIDTH];
                tag_d = TAG_W'(i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q     <= TAG_W'(NUM_REQ - 1);
            din_vld_q <= 1'b0;
            din_q     <= '0;
            tag_q     <= '0;
        end else begin
            ptr_q     <= ptr_d;
            din_vld_q <= din_vld_d;
            din_q     <= din_d;
            tag_q     <= tag_d;
        end
    end

    assign pipe_din_vld_o = din_vld_q;
    assign pipe_din_o     = din_q;

    if (LATENCY == 0) begin : g_tag_wire
        assign {dly_vld, dly_tag} = {din_vld_q, tag_q};
    end else begin : g_tag_delay
        tag_delay #(
            .STAGES (LATENCY),
            .WIDTH  (TAG_W + 1)
        ) u_tag_delay (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .d_i    ({din_vld_q, tag_q}),
            .q_o    ({dly_vld, dly_tag})
        );
    end

    // Results whose tags were discarded by reset never produce a strobe.
    always_comb begin
        rsp_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_oh[i] = rst_ni && dly_vld && (dly_tag == TAG_W'(i));
        end
        rsp_any = |rsp_oh;
    end

    assign req_if.rsp_vld = rsp_oh;
    assign req_if.rsp_dat = pipe_dout_i;

    always_comb begin
        cnt_d = cnt_q;
        case ({xfer, rsp_any})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign inflight_o = cnt_q;
    assign idle_o     = (cnt_q == '0) && (req_if.req_vld == '0);

endmodule
